// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } btn_state_t;

  // Bits needed to hold every value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce FSM, press/release pulses and
// an optional hold-to-repeat timer.
module btn_channel
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign act = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  btn_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            hold_run, hold_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_run  = 1'b0;
    hold_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (act) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = PRESSED;
            press_d  = 1'b1;
            level_d  = 1'b1;
            hold_clr = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CntW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = PRESSED;
          press_d  = 1'b1;
          level_d  = 1'b1;
          hold_clr = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        // Timer runs on every PRESSED cycle, including the one that leaves it.
        hold_run = 1'b1;
        if (!act) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            release_d = 1'b1;
            level_d   = 1'b0;
            hold_run  = 1'b0;
            hold_clr  = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = CntW'(1);
          end
        end
      end
      RELEASE_DB: begin
        if (act) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          hold_clr  = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

  if (REPEAT_EN) begin : g_repeat
    localparam int unsigned TmrW = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TmrW-1:0] HoldLast = TmrW'(HOLD_CYCLES - 1);
    localparam logic [TmrW-1:0] RepLast  = TmrW'(REPEAT_CYCLES - 1);

    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            phase_q, phase_d;
    logic            rep_q, rep_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tmr_q   <= '0;
        phase_q <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        tmr_q   <= tmr_d;
        phase_q <= phase_d;
        rep_q   <= rep_d;
      end
    end

    // phase_q: 0 = waiting for the first repeat, 1 = periodic repeats.
    always_comb begin
      tmr_d   = tmr_q;
      phase_d = phase_q;
      rep_d   = 1'b0;
      if (hold_clr) begin
        tmr_d   = '0;
        phase_d = 1'b0;
      end else if (hold_run) begin
        if (tmr_q == (phase_q ? RepLast : HoldLast)) begin
          rep_d   = 1'b1;
          phase_d = 1'b1;
          tmr_d   = '0;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    end

    assign repeat_pulse = rep_q;
  end else begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: N_BTN independent debounced channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn_in[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // OR of registered pulses, so it carries the same one-cycle timing.
  assign any_press = |press_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// checked every cycle against a run-length reference model.
module tb_btn_conditioner;

  localparam int unsigned N  = 2;
  localparam int unsigned S  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned H  = 10;
  localparam int unsigned R  = 5;
  localparam bit          AL = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] level, press_pulse, release_pulse, repeat_pulse;
  logic         any_press;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN           (N),
    .ACTIVE_LOW      (AL),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1'b1),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history, run length of samples disagreeing with the
  // accepted level, and cycles spent stably held since the press.
  bit [S-1:0]   sync_m [N];
  bit           lvl_m  [N];
  int           run_m  [N];
  int           el_m   [N];
  logic [N-1:0] exp_level, exp_press, exp_release, exp_repeat;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      sync_m[c] = {S{AL}};
      lvl_m[c]  = 1'b0;
      run_m[c]  = 0;
      el_m[c]   = 0;
    end
    exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit act;
      bit held;
      act  = sync_m[c][S-1] ^ AL;
      held = lvl_m[c] && (run_m[c] == 0);
      exp_press[c] = 1'b0; exp_release[c] = 1'b0; exp_repeat[c] = 1'b0;
      if (act != lvl_m[c]) begin
        run_m[c]++;
        if (run_m[c] == D) begin
          lvl_m[c] = ~lvl_m[c];
          run_m[c] = 0;
          if (lvl_m[c]) exp_press[c] = 1'b1;
          else          exp_release[c] = 1'b1;
        end
      end else begin
        run_m[c] = 0;
      end
      if (held && !exp_release[c]) begin
        el_m[c]++;
        if (el_m[c] >= H && ((el_m[c] - H) % R) == 0) exp_repeat[c] = 1'b1;
      end
      if (exp_press[c] || exp_release[c]) el_m[c] = 0;
      exp_level[c] = lvl_m[c];
      sync_m[c] = {sync_m[c][S-2:0], btn_in[c]};
    end
  endtask

  task automatic compare();
    check("level",   32'(level),         32'(exp_level));
    check("press",   32'(press_pulse),   32'(exp_press));
    check("release", 32'(release_pulse), 32'(exp_release));
    check("repeat",  32'(repeat_pulse),  32'(exp_repeat));
    check("any",     32'(any_press),     32'(|exp_press));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    step();
    reset = 1'b0;
  endtask

  int           k, cnt, first, last;
  logic [N-1:0] acc, dual;
  int           rem [N];

  initial begin
    // 1: reset and idle
    reset  = 1'b1;
    btn_in = '1;
    model_reset();
    run(3);
    reset = 1'b0;
    acc   = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc |= level | press_pulse | release_pulse | repeat_pulse | {N{any_press}};
    end
    check("idle_quiet", 32'(acc), 32'(0));

    // 2: clean press on channel 0
    btn_in[0] = 1'b0;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (k == 0 && press_pulse[0]) begin
        k = i;
        check("any_on_press", 32'(any_press), 32'(1));
        check("ch1_untouched", 32'({level[1], press_pulse[1]}), 32'(0));
      end
    end
    check("press_lat", 32'(k), 32'(6));
    check("press_level", 32'(level[0]), 32'(1));
    btn_in[0] = 1'b1;
    run(12);
    check("released", 32'(level[0]), 32'(0));

    // 3: 3-cycle glitch rejected, then a real press
    btn_in[0] = 1'b0;
    run(3);
    btn_in[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (press_pulse[0] || level[0]) cnt++;
    end
    check("glitch_rej", 32'(cnt), 32'(0));
    btn_in[0] = 1'b0;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (k == 0 && press_pulse[0]) k = i;
      if (k != 0) break;
    end
    check("press_lat2", 32'(k), 32'(6));

    // 4: auto-repeat schedule while held
    cnt = 0; first = 0; last = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (repeat_pulse[0]) begin
        if (first == 0) first = i;
        last = i;
        cnt++;
      end
    end
    check("rep_first", 32'(first), 32'(10));
    check("rep_last",  32'(last),  32'(30));
    check("rep_count", 32'(cnt),   32'(5));

    // 5: 2-cycle release bounce shifts the schedule, then a real release
    btn_in[0] = 1'b1;
    run(2);
    btn_in[0] = 1'b0;
    cnt = 0; first = 0;
    for (int j = 3; j <= 14; j++) begin
      step();
      if (release_pulse[0] || press_pulse[0]) cnt++;
      if (first == 0 && repeat_pulse[0]) first = j;
    end
    check("bounce_no_edge", 32'(cnt), 32'(0));
    check("rep_shift", 32'(first), 32'(7));
    btn_in[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (k == 0 && release_pulse[0]) k = i;
    end
    check("rel_lat", 32'(k), 32'(6));
    check("rel_level", 32'(level[0]), 32'(0));

    // 6: simultaneous presses, then reset while held
    btn_in = '0;
    dual = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dual == '0 && press_pulse != '0) dual = press_pulse;
    end
    check("dual_press", 32'(dual), 32'(2'b11));
    run(5);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async", 32'({level, press_pulse, release_pulse, repeat_pulse, any_press}), 32'(0));
    btn_in = '1;
    run(3);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (release_pulse != '0 || level != '0) cnt++;
    end
    check("no_rel_after_rst", 32'(cnt), 32'(0));

    // Random activity: mixes glitches, clean presses and long holds.
    for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 10);
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 45) : $urandom_range(1, 5);
        end
      end
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
